// File: rtl/frame_check_if.sv
// Receive-side stream bundle: raw GTP words in, byte-aligned words out.
interface frame_check_if;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [1:0]  rx_is_k;
    logic [15:0] aligned_data;
    logic [1:0]  aligned_is_k;
    logic        aligned_valid;
    logic        frame_start;

    modport master (
        output rx_valid, rx_data, rx_is_k,
        input  aligned_data, aligned_is_k, aligned_valid, frame_start
    );

    modport slave (
        input  rx_valid, rx_data, rx_is_k,
        output aligned_data, aligned_is_k, aligned_valid, frame_start
    );
endinterface

// File: rtl/frame_check.sv
// SFP test-frame checker: aligns the GTP stream to the K28.5K28.5 comma on either
// byte phase, verifies 4-word frames, tracks link lock and keeps saturating counters.
//
// state  | meaning
// HUNT   | searching both byte lanes for the comma word
// VERIFY | comma found, confirming LOCK_FRAMES good frames
// LOCKED | link up, byte phase frozen, counting good and bad frames
module frame_check #(
    parameter logic [15:0] COMMA         = 16'hBCBC,
    parameter logic [15:0] PAYLOAD0      = 16'h5854,
    parameter logic [15:0] PAYLOAD1      = 16'h4034,
    parameter logic [15:0] PAYLOAD2      = 16'h23A7,
    parameter int          LOCK_FRAMES   = 4,
    parameter int          UNLOCK_FRAMES = 3,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    frame_check_if.slave     rx,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             byte_swap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_FRAMES + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t            state, state_nx;
    logic [1:0]        idx, idx_nx;
    logic [GOOD_W-1:0] good, good_nx;
    logic [BAD_W-1:0]  bad, bad_nx;
    logic              frame_bad, frame_bad_nx;
    logic              swap_nx, locked_nx, err_inc, frame_inc;
    logic [7:0]        prev_hi;
    logic              prev_hi_k;
    logic [15:0]       lane_b_data, sel_data, exp_data;
    logic [1:0]        lane_b_k, sel_k, exp_k;
    logic              word_ok, hit_a, hit_b;

    // Only the upper byte of the previous word is needed to build the shifted lane.
    assign lane_b_data = {rx.rx_data[7:0], prev_hi};
    assign lane_b_k    = {rx.rx_is_k[0], prev_hi_k};
    assign sel_data    = byte_swap ? lane_b_data : rx.rx_data;
    assign sel_k       = byte_swap ? lane_b_k : rx.rx_is_k;

    always_comb begin
        exp_data = COMMA;
        case (idx)
            2'd1:    exp_data = PAYLOAD0;
            2'd2:    exp_data = PAYLOAD1;
            2'd3:    exp_data = PAYLOAD2;
            default: exp_data = COMMA;
        endcase
    end

    assign exp_k   = (idx == 2'd0) ? 2'b11 : 2'b00;
    assign word_ok = (sel_data == exp_data) && (sel_k == exp_k);
    assign hit_a   = (rx.rx_data == COMMA) && (rx.rx_is_k == 2'b11);
    assign hit_b   = (lane_b_data == COMMA) && (lane_b_k == 2'b11);

    assign rx.aligned_valid = (state == LOCKED);

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        good_nx      = good;
        bad_nx       = bad;
        frame_bad_nx = frame_bad;
        swap_nx      = byte_swap;
        locked_nx    = locked;
        err_inc      = 1'b0;
        frame_inc    = 1'b0;
        if (!rx.rx_valid) begin
            state_nx     = HUNT;
            locked_nx    = 1'b0;
            idx_nx       = 2'd0;
            good_nx      = '0;
            bad_nx       = '0;
            frame_bad_nx = 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (hit_a || hit_b) begin
                        swap_nx  = !hit_a;
                        idx_nx   = 2'd1;
                        good_nx  = GOOD_W'(1);
                        state_nx = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!word_ok) begin
                        err_inc  = 1'b1;
                        state_nx = HUNT;
                        idx_nx   = 2'd0;
                        good_nx  = '0;
                    end else begin
                        idx_nx = idx + 2'd1;
                        if (idx == 2'd3) begin
                            if (good == GOOD_W'(LOCK_FRAMES)) begin
                                state_nx     = LOCKED;
                                locked_nx    = 1'b1;
                                bad_nx       = '0;
                                frame_bad_nx = 1'b0;
                            end else begin
                                good_nx = good + GOOD_W'(1);
                            end
                        end
                    end
                end
                LOCKED: begin
                    idx_nx  = idx + 2'd1;
                    err_inc = !word_ok;
                    if (idx == 2'd3) begin
                        frame_bad_nx = 1'b0;
                        if (frame_bad || !word_ok) begin
                            if (bad == BAD_W'(UNLOCK_FRAMES - 1)) begin
                                state_nx  = HUNT;
                                locked_nx = 1'b0;
                                idx_nx    = 2'd0;
                                good_nx   = '0;
                                bad_nx    = '0;
                            end else begin
                                bad_nx = bad + BAD_W'(1);
                            end
                        end else begin
                            bad_nx    = '0;
                            frame_inc = 1'b1;
                        end
                    end else if (!word_ok) begin
                        frame_bad_nx = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            idx             <= 2'd0;
            good            <= '0;
            bad             <= '0;
            frame_bad       <= 1'b0;
            byte_swap       <= 1'b0;
            locked          <= 1'b0;
            prev_hi         <= 8'd0;
            prev_hi_k       <= 1'b0;
            err_cnt         <= '0;
            frame_cnt       <= '0;
            rx.aligned_data <= 16'd0;
            rx.aligned_is_k <= 2'b00;
            rx.frame_start  <= 1'b0;
        end else begin
            state           <= state_nx;
            idx             <= idx_nx;
            good            <= good_nx;
            bad             <= bad_nx;
            frame_bad       <= frame_bad_nx;
            byte_swap       <= swap_nx;
            locked          <= locked_nx;
            prev_hi         <= rx.rx_data[15:8];
            prev_hi_k       <= rx.rx_is_k[1];
            rx.aligned_data <= sel_data;
            rx.aligned_is_k <= sel_k;
            rx.frame_start  <= (state == LOCKED) && (idx == 2'd0);
            // Clear wins over a same-cycle increment.
            if (clr_cnt)
                err_cnt <= '0;
            else if (err_inc && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
            if (clr_cnt)
                frame_cnt <= '0;
            else if (frame_inc && (frame_cnt != '1))
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
endmodule
